// File: rtl/card_shoe_if.sv
// Handshake bundle between a dealer client (master) and the card shoe (slave).
interface card_shoe_if;
  logic       i_shuffle;
  logic       i_draw;
  logic [5:0] o_card;
  logic       o_cardValid;
  logic       o_ready;
  logic       o_busy;
  logic [5:0] o_cardsLeft;
  logic       o_drawError;

  modport master (
    output i_shuffle, i_draw,
    input  o_card, o_cardValid, o_ready, o_busy, o_cardsLeft, o_drawError
  );

  modport slave (
    input  i_shuffle, i_draw,
    output o_card, o_cardValid, o_ready, o_busy, o_cardsLeft, o_drawError
  );
endinterface

// File: rtl/card_shoe.sv
// 52-card shoe: one-cycle deck rebuild, LFSR-driven Fisher-Yates shuffle, 1-cycle deal.
// Optional CARD_SHOE_AUTO_RESHUFFLE_EN: a draw on an empty deck reshuffles and is served afterwards.
module card_shoe #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_RETRY = 8
) (
  input logic       i_clk,
  input logic       i_reset_n,
  card_shoe_if.slave bus
);
  localparam logic [1:0] S_INIT    = 2'd0;
  localparam logic [1:0] S_SHUFFLE = 2'd1;
  localparam logic [1:0] S_READY   = 2'd2;
  localparam logic [1:0] S_EMPTY   = 2'd3;

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int          RW       = $clog2(MAX_RETRY + 1);

  logic [1:0]    state;
  logic [5:0]    deck [52];
  logic [5:0]    top;
  logic [5:0]    idx;
  logic [RW-1:0] retryCnt;
  logic [15:0]   lfsr;
  logic [15:0]   lfsrNext;
  logic [5:0]    card;
  logic          cardValid;
  logic [5:0]    cardsLeft;
  logic          drawError;
  logic          drawReq;

  logic [5:0] idxMask;
  logic [5:0] cand;
  logic       candOk;
  logic       forceAcc;
  logic [5:0] swapJ;

  assign lfsrNext = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

  // Smearing the index right yields the smallest all-ones mask covering it.
  assign idxMask  = idx | (idx >> 1) | (idx >> 2) | (idx >> 3) | (idx >> 4) | (idx >> 5);
  assign cand     = lfsr[5:0] & idxMask;
  assign candOk   = (cand <= idx);
  assign forceAcc = !candOk && (retryCnt == RW'(MAX_RETRY - 1));
  assign swapJ    = candOk ? cand : 6'd0;

`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
  logic pendDraw;
  assign drawReq = bus.i_draw | pendDraw;
`else
  assign drawReq = bus.i_draw;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state     <= S_INIT;
      lfsr      <= SEED_EFF;
      card      <= 6'd0;
      cardValid <= 1'b0;
      cardsLeft <= 6'd0;
      drawError <= 1'b0;
      top       <= 6'd0;
      idx       <= 6'd0;
      retryCnt  <= '0;
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
      pendDraw  <= 1'b0;
`endif
    end else begin
      lfsr      <= lfsrNext;
      cardValid <= 1'b0;
      drawError <= 1'b0;
      case (state)
        S_INIT: begin
          for (int k = 0; k < 52; k++) deck[k] <= {2'(k / 13), 4'(k % 13 + 1)};
          idx       <= 6'd51;
          top       <= 6'd0;
          retryCnt  <= '0;
          cardsLeft <= 6'd0;
          state     <= S_SHUFFLE;
        end
        S_SHUFFLE: begin
          if (candOk || forceAcc) begin
            deck[idx]   <= deck[swapJ];
            deck[swapJ] <= deck[idx];
            retryCnt    <= '0;
            if (idx == 6'd1) begin
              state     <= S_READY;
              cardsLeft <= 6'd52;
              top       <= 6'd0;
            end else begin
              idx <= idx - 1'b1;
            end
          end else begin
            retryCnt <= retryCnt + 1'b1;
          end
        end
        S_READY: begin
          if (bus.i_shuffle) begin
            state <= S_INIT;
          end else if (drawReq) begin
            card      <= deck[top];
            cardValid <= 1'b1;
            top       <= top + 1'b1;
            cardsLeft <= cardsLeft - 1'b1;
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
            pendDraw  <= 1'b0;
`endif
            if (cardsLeft == 6'd1) state <= S_EMPTY;
          end
        end
        S_EMPTY: begin
          if (bus.i_shuffle) begin
            state <= S_INIT;
          end else if (bus.i_draw) begin
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
            pendDraw <= 1'b1;
            state    <= S_INIT;
`else
            drawError <= 1'b1;
`endif
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign bus.o_card      = card;
  assign bus.o_cardValid = cardValid;
  assign bus.o_cardsLeft = cardsLeft;
  assign bus.o_drawError = drawError;
  assign bus.o_ready     = (state == S_READY);
  assign bus.o_busy      = (state == S_INIT) || (state == S_SHUFFLE);
endmodule

// File: tb/tb_card_shoe.sv
// Bench for card_shoe: transaction-level model (whole-deck shuffle per rebuild, queue of cards) checked every cycle.
module tb_card_shoe;
  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          MAX_RETRY = 8;
  localparam int          BUDGET    = 1 + 51 * MAX_RETRY;
  localparam int M_INIT = 0, M_SHUF = 1, M_READY = 2, M_EMPTY = 3;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  card_shoe_if bus ();

  card_shoe #(.SEED(SEED), .MAX_RETRY(MAX_RETRY)) dut (
    .i_clk(clk), .i_reset_n(rstN), .bus(bus)
  );

  always #5 clk = ~clk;

  int nPass = 0, nTot = 0;
  bit chkOn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTot++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- model ----------------
  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int maskOf(input int i);
    int m = 0;
    while (m < i) m = m * 2 + 1;
    return m;
  endfunction

  int          mState = M_INIT;
  logic [15:0] mLfsr;
  logic [5:0]  mDeck[$];
  int          mShufDone = 0, mShufTotal = 0, mCyc20 = 0;
  logic [5:0]  expCard;
  logic        expValid, expErr;
  int          expLeft;
  bit          mPend = 0;

  // Full shuffle from the LFSR value seen on the first shuffle cycle.
  task automatic buildDeck(input logic [15:0] l0);
    logic [5:0]  d[52];
    logic [15:0] l;
    logic [5:0]  t;
    int          j, tries;
    bit          done;
    l = l0;
    mShufTotal = 0;
    for (int k = 0; k < 52; k++) d[k] = 6'((k / 13) * 16 + (k % 13) + 1);
    for (int i = 51; i >= 1; i--) begin
      if (i == 20) mCyc20 = mShufTotal;
      tries = 0;
      done  = 0;
      while (!done) begin
        j = int'(l[5:0]) & maskOf(i);
        l = lfsrStep(l);
        mShufTotal++;
        if (j <= i) done = 1;
        else begin
          tries++;
          if (tries == MAX_RETRY) begin j = 0; done = 1; end
        end
      end
      t = d[i]; d[i] = d[j]; d[j] = t;
    end
    mDeck.delete();
    for (int k = 0; k < 52; k++) mDeck.push_back(d[k]);
  endtask

  always @(posedge clk) begin
    if (!rstN) begin
      mState = M_INIT; mLfsr = SEED; expCard = 0; expValid = 0; expErr = 0; expLeft = 0; mPend = 0;
    end else begin
      mLfsr    = lfsrStep(mLfsr);
      expValid = 0;
      expErr   = 0;
      case (mState)
        M_INIT: begin expLeft = 0; mState = M_SHUF; mShufDone = 0; buildDeck(mLfsr); end
        M_SHUF: begin
          mShufDone++;
          if (mShufDone == mShufTotal) begin mState = M_READY; expLeft = 52; end
        end
        M_READY: begin
          if (bus.i_shuffle) mState = M_INIT;
          else if (bus.i_draw || mPend) begin
            expCard = mDeck.pop_front(); expValid = 1; expLeft--; mPend = 0;
            if (expLeft == 0) mState = M_EMPTY;
          end
        end
        default: begin
          if (bus.i_shuffle) mState = M_INIT;
          else if (bus.i_draw) begin
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
            mPend = 1; mState = M_INIT;
`else
            expErr = 1;
`endif
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chkOn) begin
      chk("cmp_card", bus.o_card, expCard);
      chk("cmp_valid", bus.o_cardValid, expValid);
      chk("cmp_drawErr", bus.o_drawError, expErr);
      chk("cmp_left", bus.o_cardsLeft, expLeft);
      chk("cmp_ready", bus.o_ready, mState == M_READY);
      chk("cmp_busy", bus.o_busy, (mState == M_INIT) || (mState == M_SHUF));
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0] dealt[52];
  logic [5:0] firstDeck[$];
  int         firstTotal;

  task automatic waitReady(input string nm, output int n);
    n = 0;
    while (!bus.o_ready && n < BUDGET + 2) begin @(negedge clk); n++; end
    chk({nm, "_inBudget"}, n <= BUDGET, 1);
  endtask

  task automatic dealN(input int n);
    bus.i_draw = 1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      dealt[k] = bus.o_card;
      chk("dealStrobe", bus.o_cardValid, 1);
    end
    bus.i_draw = 0;
  endtask

  task automatic checkResetOutputs(input string nm);
    chk({nm, "_card"}, bus.o_card, 0);
    chk({nm, "_valid"}, bus.o_cardValid, 0);
    chk({nm, "_ready"}, bus.o_ready, 0);
    chk({nm, "_busy"}, bus.o_busy, 1);
    chk({nm, "_left"}, bus.o_cardsLeft, 0);
    chk({nm, "_err"}, bus.o_drawError, 0);
  endtask

  initial begin
    int n;
    int nDistinct;
    bit seen[64];
    logic [5:0] lastCard;
    bus.i_shuffle = 0;
    bus.i_draw    = 0;

    // model pins
    chk("pin_lfsrStep", lfsrStep(16'hACE1), 16'hE270);
    chk("pin_mask51", maskOf(51), 63);
    chk("pin_mask16", maskOf(16), 31);
    chk("pin_mask15", maskOf(15), 15);
    chk("pin_mask1", maskOf(1), 1);

    @(negedge clk); @(negedge clk);
    chkOn = 1;
    checkResetOutputs("reset");
    rstN = 1;

    // boot: init + shuffle, then a full deck
    waitReady("boot", n);
    chk("bootCycles", n, 1 + mShufTotal);
    chk("bootLeft", bus.o_cardsLeft, 52);
    firstDeck  = mDeck;
    firstTotal = mShufTotal;

    // deal the whole deck with draw held high
    dealN(52);
    nDistinct = 0;
    foreach (seen[k]) seen[k] = 0;
    for (int k = 0; k < 52; k++) begin
      if (!seen[dealt[k]] && dealt[k][3:0] >= 1 && dealt[k][3:0] <= 13) nDistinct++;
      seen[dealt[k]] = 1;
    end
    chk("distinctCards", nDistinct, 52);
    chk("emptyReady", bus.o_ready, 0);
    chk("emptyLeft", bus.o_cardsLeft, 0);

    // draw on empty deck
    lastCard = bus.o_card;
    bus.i_draw = 1;
    @(negedge clk);
    bus.i_draw = 0;
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
    chk("autoNoErr", bus.o_drawError, 0);
    chk("autoBusy", bus.o_busy, 1);
    waitReady("autoReshuf", n);
    @(negedge clk);
    chk("autoServed", bus.o_cardValid, 1);
    chk("autoLeft", bus.o_cardsLeft, 51);
`else
    chk("emptyDrawErr", bus.o_drawError, 1);
    chk("emptyNoCard", bus.o_cardValid, 0);
    chk("emptyCardHeld", bus.o_card, lastCard);
    @(negedge clk);
    chk("emptyErrOneCycle", bus.o_drawError, 0);
`endif

    // reshuffle; draw and shuffle requests during the shuffle are ignored
    bus.i_shuffle = 1;
    @(negedge clk);
    bus.i_shuffle = 0;
    bus.i_draw    = 1;
    repeat (3) @(negedge clk);
    bus.i_draw    = 0;
    bus.i_shuffle = 1;
    @(negedge clk);
    bus.i_shuffle = 0;
    waitReady("reshuf", n);
    chk("reshufLeft", bus.o_cardsLeft, 52);

    // shuffle beats draw with 30 cards left
    dealN(22);
    chk("left30", bus.o_cardsLeft, 30);
    bus.i_shuffle = 1;
    bus.i_draw    = 1;
    @(negedge clk);
    bus.i_shuffle = 0;
    bus.i_draw    = 0;
    chk("shufWinsNoCard", bus.o_cardValid, 0);
    @(negedge clk);
    chk("shufWinsBusy", bus.o_busy, 1);
    waitReady("shufWins", n);
    chk("shufWinsLeft", bus.o_cardsLeft, 52);

    // reset while the shuffle sits at i=20
    bus.i_shuffle = 1;
    @(negedge clk);
    bus.i_shuffle = 0;
    n = 0;
    while (!(mState == M_SHUF && mShufDone == mCyc20) && n < BUDGET + 4) begin @(negedge clk); n++; end
    chk("reachI20", n < BUDGET + 4, 1);
    rstN = 0;
    @(negedge clk);
    checkResetOutputs("midReset");
    rstN = 1;
    waitReady("afterReset", n);
    chk("afterResetCycles", n, 1 + firstTotal);
    dealN(52);
    for (int k = 0; k < 52; k++) chk("replaySeq", dealt[k], firstDeck[k]);

    @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nTot);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", nPass, nTot);
    $fatal(1, "watchdog");
  end
endmodule
